// File: rtl/sysahb_reg_slice_pkg.sv
// Shared AHB-Lite encodings and slice state encoding for the system AHB register slice.
package sysahb_reg_slice_pkg;

    typedef logic [1:0] htrans_t;

    localparam htrans_t HTRANS_IDLE   = 2'b00;
    localparam htrans_t HTRANS_BUSY   = 2'b01;
    localparam htrans_t HTRANS_NONSEQ = 2'b10;
    localparam htrans_t HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MADDR = 3'd1,
        ST_MDATA = 3'd2,
        ST_ERR1  = 3'd3,
        ST_ERR2  = 3'd4
    } state_t;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic is_active(input htrans_t t);
        return t[1];
    endfunction

endpackage

// File: rtl/sysahb_reg_slice_if.sv
// AHB-Lite bus bundle; the master modport drives the address/control/write data side.
interface sysahb_reg_slice_if
    import sysahb_reg_slice_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] haddr;
    htrans_t       htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic          hresp;
    logic [DW-1:0] hrdata;

    modport master (
        output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/sysahb_reg_slice.sv
// Fully registered AHB-Lite slice: one upstream transfer is replayed downstream as a
// single NONSEQ/SINGLE transfer and its response returned one cycle after completion.
module sysahb_reg_slice
    import sysahb_reg_slice_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic               sys_clk,
    input  logic               sys_resetn,
    sysahb_reg_slice_if.slave  s_ahb,
    sysahb_reg_slice_if.master m_ahb
);

    state_t        r_state;
    logic          r_s_hready;
    logic          r_s_hresp;
    logic [DW-1:0] r_s_hrdata;
    htrans_t       r_m_htrans;
    logic [AW-1:0] r_m_haddr;
    logic          r_m_hwrite;
    logic [2:0]    r_m_hsize;
    logic [3:0]    r_m_hprot;
    logic [DW-1:0] r_m_hwdata;

    logic w_accept;

    // Upstream HREADY is high only in IDLE and ERR2, so those are the only accept points.
    assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_ERR2)) && is_active(s_ahb.htrans);

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_state    <= ST_IDLE;
            r_s_hready <= 1'b1;
            r_s_hresp  <= HRESP_OKAY;
            r_s_hrdata <= '0;
            r_m_htrans <= HTRANS_IDLE;
            r_m_haddr  <= '0;
            r_m_hwrite <= 1'b0;
            r_m_hsize  <= '0;
            r_m_hprot  <= '0;
            r_m_hwdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERR2: begin
                    r_s_hresp <= HRESP_OKAY;
                    if (w_accept) begin
                        r_state    <= ST_MADDR;
                        r_s_hready <= 1'b0;
                        r_m_htrans <= HTRANS_NONSEQ;
                        r_m_haddr  <= s_ahb.haddr;
                        r_m_hwrite <= s_ahb.hwrite;
                        r_m_hsize  <= s_ahb.hsize;
                        r_m_hprot  <= s_ahb.hprot;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_s_hready <= 1'b1;
                    end
                end
                ST_MADDR: begin
                    // This cycle is the upstream data phase, so write data is valid here.
                    r_m_hwdata <= s_ahb.hwdata;
                    if (m_ahb.hready) begin
                        r_state    <= ST_MDATA;
                        r_m_htrans <= HTRANS_IDLE;
                    end
                end
                ST_MDATA: begin
                    if (m_ahb.hresp == HRESP_ERROR) begin
                        r_state   <= ST_ERR1;
                        r_s_hresp <= HRESP_ERROR;
                    end else if (m_ahb.hready) begin
                        r_state    <= ST_IDLE;
                        r_s_hready <= 1'b1;
                        if (!r_m_hwrite) begin
                            r_s_hrdata <= m_ahb.hrdata;
                        end
                    end
                end
                ST_ERR1: begin
                    r_state    <= ST_ERR2;
                    r_s_hready <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_s_hready <= 1'b1;
                    r_s_hresp  <= HRESP_OKAY;
                    r_m_htrans <= HTRANS_IDLE;
                end
            endcase
        end
    end

    assign s_ahb.hready = r_s_hready;
    assign s_ahb.hresp  = r_s_hresp;
    assign s_ahb.hrdata = r_s_hrdata;
    assign m_ahb.haddr  = r_m_haddr;
    assign m_ahb.htrans = r_m_htrans;
    assign m_ahb.hwrite = r_m_hwrite;
    assign m_ahb.hsize  = r_m_hsize;
    assign m_ahb.hburst = HBURST_SINGLE;
    assign m_ahb.hprot  = r_m_hprot;
    assign m_ahb.hwdata = r_m_hwdata;

endmodule

// File: doc/sysahb_reg_slice.md
Name: sysahb_reg_slice

Overview:
- Full AHB-Lite register slice between the CPU system AHB master port and the system AHB peripheral subsystem (BRAM, default slave, APB subsystem).
- Breaks the combinational HREADY/HRDATA/HADDR paths. Accepts one transfer at a time from the CPU and replays it downstream as a single NONSEQ transfer.
- Returns the response to the CPU one cycle after downstream completion, including the two-cycle ERROR response.

Parameters:
- AW, 32, address width.
- DW, 32, data width.

Ports:
- sys_clk  in  1  system clock
- sys_resetn  in  1  asynchronous active-low reset
- s_haddr  in  AW  upstream address
- s_htrans  in  2  upstream transfer type
- s_hwrite  in  1  upstream write
- s_hsize  in  3  upstream size
- s_hburst  in  3  upstream burst (ignored except for capture)
- s_hprot  in  4  upstream protection
- s_hwdata  in  DW  upstream write data
- s_hready  out  1  upstream HREADY
- s_hresp  out  1  upstream HRESP (0 OKAY, 1 ERROR)
- s_hrdata  out  DW  upstream read data
- m_haddr  out  AW  downstream address (to sysahb_haddr)
- m_htrans  out  2  downstream transfer type
- m_hwrite  out  1  downstream write
- m_hsize  out  3  downstream size
- m_hburst  out  3  downstream burst, always SINGLE (3'b000)
- m_hprot  out  4  downstream protection
- m_hwdata  out  DW  downstream write data
- m_hready  in  1  downstream HREADY (muxed)
- m_hresp  in  1  downstream HRESP
- m_hrdata  in  DW  downstream read data

Behaviour:
- Clock/reset: single clock sys_clk; sys_resetn asynchronous, active-low.
- Reset values: state=IDLE, s_hready=1, s_hresp=0, s_hrdata=0, m_htrans=IDLE(2'b00), m_haddr/m_hwrite/m_hsize/m_hprot/m_hwdata=0, m_hburst=0. All outputs are registered.
- Accept condition: s_hready=1 and s_htrans[1]=1 (NONSEQ or SEQ) at a sys_clk edge. On accept, capture haddr/hwrite/hsize/hprot.
- IDLE and BUSY upstream transfers are never accepted; the slice stays in IDLE with an OKAY response.
- States:
  - IDLE: s_hready=1, s_hresp=0. On accept -> MADDR.
  - MADDR: s_hready=0; m_htrans=NONSEQ with captured control. s_hwdata is captured into m_hwdata at the end of this cycle (the upstream data phase). If m_hready=1 -> MDATA; else hold.
  - MDATA: m_htrans=IDLE; m_hwdata held. If m_hready=1 and m_hresp=0 -> capture m_hrdata into s_hrdata, -> IDLE with s_hready=1 next cycle. If m_hready=0 and m_hresp=1 -> ERR1. If m_hready=0 and m_hresp=0 -> hold.
  - ERR1: s_hready=0, s_hresp=1 -> ERR2. Consumes the downstream second error cycle.
  - ERR2: s_hready=1, s_hresp=1. Accept is evaluated as in IDLE: accept -> MADDR, else -> IDLE.
- Latency: CPU address phase at T; downstream address phase at T+1. With zero-wait downstream, CPU sees s_hready=1 with data at T+3 (2 wait states). Each downstream wait state adds exactly one upstream wait state.
- Bursts: every beat is issued as NONSEQ/SINGLE. Beats are never merged or prefetched.
- s_hrdata holds its last value until the next successful read completes. It is not updated on writes or errors.
- Downstream receives only one outstanding transfer. m_htrans is NONSEQ only in MADDR.
- Reset mid-transfer: immediate return to reset values. An in-flight downstream transfer is abandoned; the downstream m_htrans=IDLE makes this legal.

Decomposition:
- Shared package/include holds:
  - HTRANS encodings: IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11.
  - HRESP OKAY/ERROR.
  - HBURST SINGLE.
  - State encoding: 3-bit IDLE/MADDR/MDATA/ERR1/ERR2.
- No sub-module: a single FSM plus a capture register bank.

Test Plan:
- Reset: assert sys_resetn=0 mid-MDATA -> next edge s_hready=1, s_hresp=0, m_htrans=2'b00, s_hrdata=0.
- Read, zero-wait: CPU NONSEQ read 0x20000010; BRAM returns 0xDEADBEEF -> m_htrans=NONSEQ at T+1 with m_haddr=0x20000010; s_hready low T+1..T+2; s_hrdata=0xDEADBEEF with s_hready=1 at T+3.
- Write with 2 downstream wait states: CPU writes 0xA5A5_0001 to 0x40000004 -> m_hwdata=0xA5A50001 during MDATA; s_hready=1 at T+5; s_hrdata unchanged.
- Error: access 0x30000000 (default slave) -> s_hresp=1 with s_hready=0 for one cycle, then s_hresp=1 with s_hready=1; downstream m_htrans stays IDLE after the address phase.
- INCR4 burst of reads from 0x20000000 -> four downstream NONSEQ/SINGLE transfers at 0x...00, 04, 08, 0C, each completing with 2 upstream wait states; data in order.
- BUSY/IDLE filtering: CPU drives BUSY then IDLE with s_hready=1 -> no downstream NONSEQ; s_hready stays 1 with s_hresp=0.
